// File: rtl/skin_pkg.sv
// skin_pkg: shared thresholds, widths and FSM type for the skin segmenter.
// SKIN_LUMA_GATE_EN adds the default luma window constants.
package skin_pkg;

   localparam int DEF_IMG_W  = 320;
   localparam int DEF_IMG_H  = 240;
   localparam int DEF_CB_MIN = 77;
   localparam int DEF_CB_MAX = 127;
   localparam int DEF_CR_MIN = 133;
   localparam int DEF_CR_MAX = 173;
   localparam int DEF_CNT_W  = 17;
`ifdef SKIN_LUMA_GATE_EN
   localparam int DEF_Y_MIN  = 40;
   localparam int DEF_Y_MAX  = 235;
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      FLUSH  = 2'd2
   } state_e;

   // index width for a dimension of n positions (at least 1 bit)
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/skin_classifier.sv
// skin_classifier: combinational Cb/Cr (and optionally Y) skin window.
// SKIN_LUMA_GATE_EN adds the Y_MIN/Y_MAX luma window.
module skin_classifier
   import skin_pkg::*;
#(
   parameter logic [7:0] CB_MIN = 8'(DEF_CB_MIN),
   parameter logic [7:0] CB_MAX = 8'(DEF_CB_MAX),
   parameter logic [7:0] CR_MIN = 8'(DEF_CR_MIN),
   parameter logic [7:0] CR_MAX = 8'(DEF_CR_MAX)
`ifdef SKIN_LUMA_GATE_EN
   ,
   parameter logic [7:0] Y_MIN  = 8'(DEF_Y_MIN),
   parameter logic [7:0] Y_MAX  = 8'(DEF_Y_MAX)
`endif
)(
   input  logic [7:0] y_in,
   input  logic [7:0] cb_in,
   input  logic [7:0] cr_in,
   output logic       skin
);

   logic cb_ok;
   logic cr_ok;
   logic y_ok;

   assign cb_ok = (cb_in >= CB_MIN) && (cb_in <= CB_MAX);
   assign cr_ok = (cr_in >= CR_MIN) && (cr_in <= CR_MAX);

`ifdef SKIN_LUMA_GATE_EN
   assign y_ok = (y_in >= Y_MIN) && (y_in <= Y_MAX);
`else
   logic unused_y;
   assign unused_y = ^y_in;
   assign y_ok     = 1'b1;
`endif

   assign skin = cb_ok & cr_ok & y_ok;

endmodule

// File: rtl/skin_segmenter.sv
// skin_segmenter: per-pixel skin mask plus per-frame count and bounding box.
// SKIN_LUMA_GATE_EN additionally gates the mask on a luma window.
module skin_segmenter
   import skin_pkg::*;
#(
   parameter int IMG_W  = DEF_IMG_W,
   parameter int IMG_H  = DEF_IMG_H,
   parameter int CB_MIN = DEF_CB_MIN,
   parameter int CB_MAX = DEF_CB_MAX,
   parameter int CR_MIN = DEF_CR_MIN,
   parameter int CR_MAX = DEF_CR_MAX,
`ifdef SKIN_LUMA_GATE_EN
   parameter int Y_MIN  = DEF_Y_MIN,
   parameter int Y_MAX  = DEF_Y_MAX,
`endif
   parameter int CNT_W  = DEF_CNT_W
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      pix_valid,
   input  logic                      pix_sof,
   input  logic [7:0]                y_in,
   input  logic [7:0]                cb_in,
   input  logic [7:0]                cr_in,
   output logic                      mask_valid,
   output logic                      mask_out,
   output logic [idx_w(IMG_W)-1:0]   mask_x,
   output logic [idx_w(IMG_H)-1:0]   mask_y,
   output logic                      frm_done,
   output logic                      frm_abort,
   output logic [CNT_W-1:0]          skin_cnt,
   output logic [idx_w(IMG_W)-1:0]   bbox_xmin,
   output logic [idx_w(IMG_W)-1:0]   bbox_xmax,
   output logic [idx_w(IMG_H)-1:0]   bbox_ymin,
   output logic [idx_w(IMG_H)-1:0]   bbox_ymax,
   output logic                      bbox_valid
);

   localparam int XW = idx_w(IMG_W);
   localparam int YW = idx_w(IMG_H);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

   state_e           state_q, state_d;
   logic [XW-1:0]    x_q, x_d;
   logic [YW-1:0]    y_q, y_d;
   logic             s1_valid_q, s1_valid_d;
   logic             s1_skin_q, s1_skin_d;
   logic             s1_sof_q, s1_sof_d;
   logic             s1_last_q, s1_last_d;
   logic [XW-1:0]    s1_x_q, s1_x_d;
   logic [YW-1:0]    s1_y_q, s1_y_d;
   logic             mask_valid_q, mask_valid_d;
   logic             mask_q, mask_d;
   logic             s2_last_q, s2_last_d;
   logic [XW-1:0]    mask_x_q, mask_x_d;
   logic [YW-1:0]    mask_y_q, mask_y_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [XW-1:0]    run_xmin_q, run_xmin_d, run_xmax_q, run_xmax_d;
   logic [YW-1:0]    run_ymin_q, run_ymin_d, run_ymax_q, run_ymax_d;
   logic             frm_done_q, frm_done_d;
   logic             frm_abort_q, frm_abort_d;
   logic [CNT_W-1:0] skin_cnt_q, skin_cnt_d;
   logic [XW-1:0]    bbox_xmin_q, bbox_xmin_d, bbox_xmax_q, bbox_xmax_d;
   logic [YW-1:0]    bbox_ymin_q, bbox_ymin_d, bbox_ymax_q, bbox_ymax_d;
   logic             bbox_valid_q, bbox_valid_d;

   logic             skin;
   logic             accept;
   logic             pix_last;
   logic [XW-1:0]    pix_x;
   logic [YW-1:0]    pix_y;

   skin_classifier #(
      .CB_MIN (8'(CB_MIN)),
      .CB_MAX (8'(CB_MAX)),
      .CR_MIN (8'(CR_MIN)),
`ifdef SKIN_LUMA_GATE_EN
      .Y_MIN  (8'(Y_MIN)),
      .Y_MAX  (8'(Y_MAX)),
`endif
      .CR_MAX (8'(CR_MAX))
   ) u_cls (
      .y_in  (y_in),
      .cb_in (cb_in),
      .cr_in (cr_in),
      .skin  (skin)
   );

   // frame FSM, raster position and stage-1 capture
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      frm_abort_d = 1'b0;
      pix_x       = pix_sof ? '0 : x_q;
      pix_y       = pix_sof ? '0 : y_q;
      pix_last    = (pix_x == X_LAST) && (pix_y == Y_LAST);
      unique case (state_q)
         IDLE:    accept = pix_valid & pix_sof;
         ACTIVE:  accept = pix_valid;
         FLUSH:   accept = pix_valid & pix_sof;
         default: accept = 1'b0;
      endcase
      if (accept) begin
         state_d     = pix_last ? FLUSH : ACTIVE;
         frm_abort_d = pix_sof & (state_q == ACTIVE);
         if (pix_last) begin
            x_d = '0;
            y_d = '0;
         end else if (pix_x == X_LAST) begin
            x_d = '0;
            y_d = pix_y + 1'b1;
         end else begin
            x_d = pix_x + 1'b1;
            y_d = pix_y;
         end
      end else if (state_q == FLUSH) begin
         state_d = IDLE;
      end
      s1_valid_d = accept;
      s1_skin_d  = accept & skin;
      s1_sof_d   = accept & pix_sof;
      s1_last_d  = accept & pix_last;
      s1_x_d     = accept ? pix_x : s1_x_q;
      s1_y_d     = accept ? pix_y : s1_y_q;
   end

   // stage 2: mask output, running accumulators, end-of-frame publish
   always_comb begin
      mask_valid_d = s1_valid_q;
      mask_d       = s1_skin_q;
      s2_last_d    = s1_last_q;
      mask_x_d     = s1_valid_q ? s1_x_q : mask_x_q;
      mask_y_d     = s1_valid_q ? s1_y_q : mask_y_q;
      run_cnt_d    = run_cnt_q;
      run_xmin_d   = run_xmin_q;
      run_xmax_d   = run_xmax_q;
      run_ymin_d   = run_ymin_q;
      run_ymax_d   = run_ymax_q;
      if (s1_sof_q) begin
         run_cnt_d  = '0;
         run_xmin_d = '1;
         run_xmax_d = '0;
         run_ymin_d = '1;
         run_ymax_d = '0;
      end
      if (s1_skin_q) begin
         run_cnt_d = run_cnt_d + 1'b1;
         if (s1_x_q < run_xmin_d) run_xmin_d = s1_x_q;
         if (s1_x_q > run_xmax_d) run_xmax_d = s1_x_q;
         if (s1_y_q < run_ymin_d) run_ymin_d = s1_y_q;
         if (s1_y_q > run_ymax_d) run_ymax_d = s1_y_q;
      end
      frm_done_d   = s2_last_q;
      skin_cnt_d   = skin_cnt_q;
      bbox_valid_d = bbox_valid_q;
      bbox_xmin_d  = bbox_xmin_q;
      bbox_xmax_d  = bbox_xmax_q;
      bbox_ymin_d  = bbox_ymin_q;
      bbox_ymax_d  = bbox_ymax_q;
      if (s2_last_q) begin
         skin_cnt_d   = run_cnt_q;
         bbox_valid_d = (run_cnt_q != '0);
         bbox_xmin_d  = bbox_valid_d ? run_xmin_q : '0;
         bbox_xmax_d  = bbox_valid_d ? run_xmax_q : '0;
         bbox_ymin_d  = bbox_valid_d ? run_ymin_q : '0;
         bbox_ymax_d  = bbox_valid_d ? run_ymax_q : '0;
      end
   end

   // all state registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         x_q          <= '0;
         y_q          <= '0;
         s1_valid_q   <= 1'b0;
         s1_skin_q    <= 1'b0;
         s1_sof_q     <= 1'b0;
         s1_last_q    <= 1'b0;
         s1_x_q       <= '0;
         s1_y_q       <= '0;
         mask_valid_q <= 1'b0;
         mask_q       <= 1'b0;
         s2_last_q    <= 1'b0;
         mask_x_q     <= '0;
         mask_y_q     <= '0;
         run_cnt_q    <= '0;
         run_xmin_q   <= '1;
         run_xmax_q   <= '0;
         run_ymin_q   <= '1;
         run_ymax_q   <= '0;
         frm_done_q   <= 1'b0;
         frm_abort_q  <= 1'b0;
         skin_cnt_q   <= '0;
         bbox_xmin_q  <= '0;
         bbox_xmax_q  <= '0;
         bbox_ymin_q  <= '0;
         bbox_ymax_q  <= '0;
         bbox_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         s1_valid_q   <= s1_valid_d;
         s1_skin_q    <= s1_skin_d;
         s1_sof_q     <= s1_sof_d;
         s1_last_q    <= s1_last_d;
         s1_x_q       <= s1_x_d;
         s1_y_q       <= s1_y_d;
         mask_valid_q <= mask_valid_d;
         mask_q       <= mask_d;
         s2_last_q    <= s2_last_d;
         mask_x_q     <= mask_x_d;
         mask_y_q     <= mask_y_d;
         run_cnt_q    <= run_cnt_d;
         run_xmin_q   <= run_xmin_d;
         run_xmax_q   <= run_xmax_d;
         run_ymin_q   <= run_ymin_d;
         run_ymax_q   <= run_ymax_d;
         frm_done_q   <= frm_done_d;
         frm_abort_q  <= frm_abort_d;
         skin_cnt_q   <= skin_cnt_d;
         bbox_xmin_q  <= bbox_xmin_d;
         bbox_xmax_q  <= bbox_xmax_d;
         bbox_ymin_q  <= bbox_ymin_d;
         bbox_ymax_q  <= bbox_ymax_d;
         bbox_valid_q <= bbox_valid_d;
      end
   end

   assign mask_valid = mask_valid_q;
   assign mask_out   = mask_q;
   assign mask_x     = mask_x_q;
   assign mask_y     = mask_y_q;
   assign frm_done   = frm_done_q;
   assign frm_abort  = frm_abort_q;
   assign skin_cnt   = skin_cnt_q;
   assign bbox_xmin  = bbox_xmin_q;
   assign bbox_xmax  = bbox_xmax_q;
   assign bbox_ymin  = bbox_ymin_q;
   assign bbox_ymax  = bbox_ymax_q;
   assign bbox_valid = bbox_valid_q;

endmodule
